serial_tx_scheduler: RTL



---
 rtl/serial_tx_scheduler_if.sv | 38 +++
 rtl/serial_tx_scheduler.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/serial_tx_scheduler_if.sv
// ---------------------------------------------------------------------------
// serial_tx_scheduler_if
// Bundles the per-channel word handshake and the tagged serial output of
// serial_tx_scheduler.
//   in_valid/in_data/in_ready : per-channel word handshake, channel i in
//                               in_data[i*width +: width]
//   busy                      : serializer is shifting a word
//   serial_valid/serial_data  : current bit (LSB first) and its qualifier
//   serial_ch                 : source channel of the current bit
//   serial_first/serial_last  : current bit is bit 0 / bit width-1
// master = word producers and serial sink, slave = the scheduler.
// ---------------------------------------------------------------------------
interface serial_tx_scheduler_if #(
   parameter int width = 8,
   parameter int n_ch  = 4
);
   logic [n_ch-1:0]         in_valid;
   logic [n_ch*width-1:0]   in_data;
   logic [n_ch-1:0]         in_ready;
   logic                    busy;
   logic                    serial_valid;
   logic                    serial_data;
   logic [$clog2(n_ch)-1:0] serial_ch;
   logic                    serial_first;
   logic                    serial_last;

   modport master (
      output in_valid, in_data,
      input  in_ready, busy, serial_valid, serial_data, serial_ch,
             serial_first, serial_last
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, busy, serial_valid, serial_data, serial_ch,
             serial_first, serial_last
   );
endinterface

// File: rtl/serial_tx_scheduler.sv
// ---------------------------------------------------------------------------
// serial_tx_scheduler
// Shares one LSB-first serial output between n_ch word sources. Each channel
// has a one-word holding register; a round-robin scheduler hands the
// serializer to pending channels and words stream back-to-back.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : serial_tx_scheduler_if.slave (word handshake + serial output)
// ---------------------------------------------------------------------------
module serial_tx_scheduler #(
   parameter int width = 8,
   parameter int n_ch  = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   serial_tx_scheduler_if.slave bus
);
   localparam int cnt_w = $clog2(width);
   localparam int ch_w  = $clog2(n_ch);
   localparam logic [cnt_w-1:0] cnt_last = cnt_w'(width - 1);
   localparam logic [ch_w-1:0]  ch_max   = ch_w'(n_ch - 1);

   typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [n_ch-1:0]   pending_r;
   logic [width-1:0]  hold_r [n_ch];
   logic [width-1:0]  sh_r;
   logic [cnt_w-1:0]  cnt_r;
   logic [ch_w-1:0]   ch_r;
   logic [ch_w-1:0]   ptr_r;
   logic              any_pend_s;
   logic              last_bit_s;
   logic              grant_s;
   logic [ch_w-1:0]   g_s;
   logic [n_ch-1:0]   accept_s;

   // First requester at or after start, wrapping around. Scanning from the
   // farthest offset down lets the nearest one win.
   function automatic logic [ch_w-1:0] rr_pick(input logic [n_ch-1:0] req,
                                                input logic [ch_w-1:0] start);
      logic [ch_w-1:0] pick;
      int              idx;
      pick = start;
      for (int k = n_ch - 1; k >= 0; k--) begin
         idx = (int'(start) + k) % n_ch;
         if (req[idx]) begin
            pick = ch_w'(idx);
         end else begin
            pick = pick;
         end
      end
      return pick;
   endfunction

   // Scheduling decisions shared by the FSM and the datapath.
   always_comb begin
      any_pend_s = |pending_r;
      last_bit_s = (cnt_r == cnt_last);
      g_s        = rr_pick(pending_r, ptr_r);
      accept_s   = bus.in_valid & ~pending_r;
      if (state_r == IDLE) begin
         grant_s = any_pend_s;
      end else begin
         grant_s = any_pend_s && last_bit_s;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next state: a grant always lands in SHIFT, a finished word with
   // nothing pending drops back to IDLE.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (any_pend_s) state_nxt_s = SHIFT;
            else            state_nxt_s = IDLE;
         end
         SHIFT: begin
            if (last_bit_s && !any_pend_s) state_nxt_s = IDLE;
            else                           state_nxt_s = SHIFT;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Holding registers: accept only into a free slot; a grant frees the slot
   // at the same edge the word moves into the shift register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_r <= {n_ch{1'b0}};
         for (int i = 0; i < n_ch; i++) hold_r[i] <= {width{1'b0}};
      end else begin
         for (int i = 0; i < n_ch; i++) begin
            if (accept_s[i]) begin
               pending_r[i] <= 1'b1;
               hold_r[i]    <= bus.in_data[i*width +: width];
            end else if (grant_s && (g_s == ch_w'(i))) begin
               pending_r[i] <= 1'b0;
            end else begin
               pending_r[i] <= pending_r[i];
            end
         end
      end
   end

   // Serializer datapath: load on grant, otherwise shift until the last bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_r  <= {width{1'b0}};
         cnt_r <= {cnt_w{1'b0}};
         ch_r  <= {ch_w{1'b0}};
         ptr_r <= {ch_w{1'b0}};
      end else if (grant_s) begin
         sh_r  <= hold_r[g_s];
         cnt_r <= {cnt_w{1'b0}};
         ch_r  <= g_s;
         ptr_r <= (g_s == ch_max) ? {ch_w{1'b0}} : g_s + ch_w'(1);
      end else if ((state_r == SHIFT) && !last_bit_s) begin
         sh_r  <= sh_r >> 1;
         cnt_r <= cnt_r + cnt_w'(1);
      end else begin
         sh_r  <= sh_r;
         cnt_r <= cnt_r;
      end
   end

   // Output decode straight from registers; everything but in_ready is
   // forced to 0 outside SHIFT so reset zeroes the outputs immediately.
   always_comb begin
      bus.in_ready = ~pending_r;
      if (state_r == SHIFT) begin
         bus.busy         = 1'b1;
         bus.serial_valid = 1'b1;
         bus.serial_data  = sh_r[0];
         bus.serial_ch    = ch_r;
         bus.serial_first = (cnt_r == {cnt_w{1'b0}});
         bus.serial_last  = last_bit_s;
      end else begin
         bus.busy         = 1'b0;
         bus.serial_valid = 1'b0;
         bus.serial_data  = 1'b0;
         bus.serial_ch    = {ch_w{1'b0}};
         bus.serial_first = 1'b0;
         bus.serial_last  = 1'b0;
      end
   end
endmodule
